// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: registers ALU results, drives the register-file write port,
// owns ZERO/CARRY with interrupt save/restore, and forwards the pending write.
module alu_writeback_stage #(
    parameter int OPERAND_WIDTH = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alu_valid,
    input  logic [OPERAND_WIDTH-1:0] alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_carry,
    input  logic [ADDR_WIDTH-1:0]    alu_dest,
    input  logic                     alu_wr_en,
    input  logic                     alu_upd_zero,
    input  logic                     alu_upd_carry,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     int_save,
    input  logic                     int_restore,
    output logic                     rf_we,
    output logic [ADDR_WIDTH-1:0]    rf_waddr,
    output logic [OPERAND_WIDTH-1:0] rf_wdata,
    output logic                     zero_flag,
    output logic                     carry_flag,
    output logic                     fwd_valid,
    output logic [ADDR_WIDTH-1:0]    fwd_addr,
    output logic [OPERAND_WIDTH-1:0] fwd_data,
    output logic [COUNT_WIDTH-1:0]   retired_count,
    output logic                     ctl_err
);
    logic                     accept;
    logic                     valid_q, valid_d, wr_en_q, wr_en_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0]    dest_q, dest_d;
    logic [OPERAND_WIDTH-1:0] result_q, result_d;
    logic                     zero_q, zero_d, carry_q, carry_d;
    logic                     sav_zero_q, sav_zero_d, sav_carry_q, sav_carry_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     err_q, err_d;
    logic                     do_save;

    assign accept  = alu_valid & ~stall & ~flush;
    assign do_save = int_save & ~int_restore;

    always_comb begin
        valid_d     = flush ? 1'b0 : stall ? valid_q : alu_valid;
        dest_d      = accept ? alu_dest : dest_q;
        result_d    = accept ? alu_result : result_q;
        wr_en_d     = accept ? alu_wr_en : wr_en_q;
        we_d        = accept & alu_wr_en;
        count_d     = accept ? count_q + 1'b1 : count_q;
        // Restore wins over a concurrent ALU flag update.
        zero_d      = int_restore ? sav_zero_q
                    : (accept & alu_upd_zero) ? alu_zero : zero_q;
        carry_d     = int_restore ? sav_carry_q
                    : (accept & alu_upd_carry) ? alu_carry : carry_q;
        sav_zero_d  = do_save ? zero_d : sav_zero_q;
        sav_carry_d = do_save ? carry_d : sav_carry_q;
        err_d       = err_q | (int_save & int_restore);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            wr_en_q     <= 1'b0;
            we_q        <= 1'b0;
            count_q     <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            sav_zero_q  <= 1'b0;
            sav_carry_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            dest_q      <= dest_d;
            result_q    <= result_d;
            wr_en_q     <= wr_en_d;
            we_q        <= we_d;
            count_q     <= count_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            sav_zero_q  <= sav_zero_d;
            sav_carry_q <= sav_carry_d;
            err_q       <= err_d;
        end
    end

    assign rf_we         = we_q;
    assign rf_waddr      = dest_q;
    assign rf_wdata      = result_q;
    assign zero_flag     = zero_q;
    assign carry_flag    = carry_q;
    assign fwd_valid     = valid_q & wr_en_q;
    assign fwd_addr      = dest_q;
    assign fwd_data      = result_q;
    assign retired_count = count_q;
    assign ctl_err       = err_q;
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: scenario tasks with a write scoreboard checked on every rf_we.
module tb_alu_writeback_stage;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0, alu_zero = 1'b0, alu_carry = 1'b0;
    logic [7:0]  alu_result = '0;
    logic [3:0]  alu_dest = '0;
    logic        alu_wr_en = 1'b0, alu_upd_zero = 1'b0, alu_upd_carry = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, int_save = 1'b0, int_restore = 1'b0;
    logic        rf_we, zero_flag, carry_flag, fwd_valid, ctl_err;
    logic [3:0]  rf_waddr, fwd_addr;
    logic [7:0]  rf_wdata, fwd_data;
    logic [15:0] retired_count;

    int          checks = 0, failures = 0;
    logic [15:0] exp_cnt = '0;
    logic [11:0] sb[$];

    alu_writeback_stage dut (
        .clk(clk), .reset_n(reset_n), .alu_valid(alu_valid), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_dest(alu_dest),
        .alu_wr_en(alu_wr_en), .alu_upd_zero(alu_upd_zero), .alu_upd_carry(alu_upd_carry),
        .stall(stall), .flush(flush), .int_save(int_save), .int_restore(int_restore),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .zero_flag(zero_flag),
        .carry_flag(carry_flag), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .retired_count(retired_count), .ctl_err(ctl_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && rf_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write got addr=%0d data=%02h expected none", rf_waddr, rf_wdata);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    failures++;
                    $display("FAIL sb_write got addr=%0d data=%02h expected addr=%0d data=%02h",
                             rf_waddr, rf_wdata, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] res, input logic [3:0] dst,
                         input logic wr, input logic uz, input logic uc, input logic z,
                         input logic c, input logic st, input logic fl, input logic sv,
                         input logic rs);
        alu_valid = v; alu_result = res; alu_dest = dst; alu_wr_en = wr;
        alu_upd_zero = uz; alu_upd_carry = uc; alu_zero = z; alu_carry = c;
        stall = st; flush = fl; int_save = sv; int_restore = rs;
        if (v && !st && !fl) begin
            exp_cnt++;
            if (wr) sb.push_back({dst, res});
        end
    endtask

    task automatic idle();
        drive(0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, zero_flag, carry_flag, fwd_valid, fwd_addr, fwd_data,
             retired_count, ctl_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we=%b cnt=%04h z=%b c=%b fwd=%b err=%b expected all 0",
                     rf_we, retired_count, zero_flag, carry_flag, fwd_valid, ctl_err);
        end
        reset_n = 1'b1;
        tick();
        drive(1, 8'h5A, 4'd3, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        tick();
        idle();
        checks++;
        if (rf_we !== 1'b1 || fwd_data !== 8'h5A) begin
            failures++;
            $display("FAIL reset_pre_accept got we=%b data=%02h expected we=1 data=5a", rf_we, fwd_data);
        end
        #1 reset_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = '0;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, zero_flag, carry_flag, fwd_valid, fwd_addr, fwd_data,
             retired_count, ctl_err} !== '0) begin
            failures++;
            $display("FAIL reset_async got we=%b addr=%0d data=%02h z=%b c=%b fwd=%b cnt=%04h expected all 0",
                     rf_we, rf_waddr, rf_wdata, zero_flag, carry_flag, fwd_valid, retired_count);
        end
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (rf_we !== 1'b0 || retired_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_release got we=%b cnt=%04h expected we=0 cnt=0000", rf_we, retired_count);
        end
    endtask

    task automatic test_basic_write();
        drive(1, 8'h00, 4'd7, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        tick();
        idle();
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 4'd7 || rf_wdata !== 8'h00 || zero_flag !== 1'b1 ||
            carry_flag !== 1'b1 || retired_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_write got we=%b addr=%0d data=%02h z=%b c=%b cnt=%0d expected 1 7 00 1 1 1",
                     rf_we, rf_waddr, rf_wdata, zero_flag, carry_flag, retired_count);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_single_pulse got we=%b fwd=%b expected 0 0", rf_we, fwd_valid);
        end
    endtask

    task automatic test_stall_hold();
        drive(1, 8'h3C, 4'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (rf_we !== 1'b1 || retired_count !== exp_cnt) begin
            failures++;
            $display("FAIL stall_accept got we=%b cnt=%0d expected we=1 cnt=%0d", rf_we, retired_count, exp_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h77, 4'd9, 1, 1, 1, 0, 0, 1, 0, 0, 0);
            tick();
            checks++;
            if (rf_we !== 1'b0 || fwd_valid !== 1'b1 || fwd_addr !== 4'd2 || fwd_data !== 8'h3C ||
                retired_count !== exp_cnt || zero_flag !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d] got we=%b fwd=%b addr=%0d data=%02h cnt=%0d z=%b expected 0 1 2 3c %0d 1",
                         i, rf_we, fwd_valid, fwd_addr, fwd_data, retired_count, zero_flag, exp_cnt);
            end
        end
        idle();
        tick();
        checks++;
        if (fwd_valid !== 1'b0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL stall_release got fwd=%b we=%b expected 0 0", fwd_valid, rf_we);
        end
    endtask

    task automatic test_compare_flush();
        drive(1, 8'h10, 4'd1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8'h20, 4'd1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        tick();
        checks++;
        if (carry_flag !== 1'b1 || zero_flag !== 1'b1 || rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
            failures++;
            $display("FAIL compare got c=%b z=%b we=%b fwd=%b expected 1 1 0 0", carry_flag, zero_flag, rf_we, fwd_valid);
        end
        drive(1, 8'h11, 4'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 8'h99, 4'd6, 1, 1, 1, 0, 0, 1, 1, 0, 0);
        tick();
        idle();
        checks++;
        if (fwd_valid !== 1'b0 || rf_we !== 1'b0 || zero_flag !== 1'b1 || carry_flag !== 1'b1 ||
            retired_count !== exp_cnt) begin
            failures++;
            $display("FAIL flush got fwd=%b we=%b z=%b c=%b cnt=%0d expected 0 0 1 1 %0d",
                     fwd_valid, rf_we, zero_flag, carry_flag, retired_count, exp_cnt);
        end
    endtask

    task automatic test_interrupt_flags();
        drive(1, 8'h00, 4'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 8'h00, 4'd0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        tick();
        checks++;
        if (zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
            failures++;
            $display("FAIL int_update got z=%b c=%b expected 0 1", zero_flag, carry_flag);
        end
        drive(1, 8'h00, 4'd0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
        tick();
        checks++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b0 || ctl_err !== 1'b0) begin
            failures++;
            $display("FAIL int_restore got z=%b c=%b err=%b expected 1 0 0", zero_flag, carry_flag, ctl_err);
        end
        // Save concurrent with an update must capture the post-update pair.
        drive(1, 8'h00, 4'd0, 0, 1, 1, 0, 1, 0, 0, 1, 0);
        tick();
        drive(1, 8'h00, 4'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
            failures++;
            $display("FAIL int_save_post_update got z=%b c=%b expected 0 1", zero_flag, carry_flag);
        end
        drive(1, 8'h00, 4'd0, 0, 1, 1, 1, 0, 0, 0, 1, 1);
        tick();
        idle();
        checks++;
        if (ctl_err !== 1'b1 || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
            failures++;
            $display("FAIL int_conflict got err=%b z=%b c=%b expected 1 0 1", ctl_err, zero_flag, carry_flag);
        end
        drive(1, 8'h00, 4'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        tick();
        drive(0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        repeat (2) tick();
        checks++;
        if (ctl_err !== 1'b1 || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
            failures++;
            $display("FAIL int_sticky got err=%b z=%b c=%b expected 1 0 1", ctl_err, zero_flag, carry_flag);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'hA0 + i), 4'(i + 8), 1, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            checks++;
            if (rf_we !== 1'b1 || rf_wdata !== 8'(8'hA0 + i) || retired_count !== exp_cnt) begin
                failures++;
                $display("FAIL b2b[%0d] got we=%b data=%02h cnt=%0d expected 1 %02h %0d",
                         i, rf_we, rf_wdata, retired_count, 8'(8'hA0 + i), exp_cnt);
            end
        end
        idle();
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got pending=%0d expected 0", sb.size());
        end
    endtask

    task automatic test_counter_wrap();
        while (exp_cnt != 16'hFFFF) begin
            drive(1, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        tick();
        checks++;
        if (retired_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL cnt_max got %04h expected ffff", retired_count);
        end
        drive(1, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        checks++;
        if (retired_count !== 16'h0000) begin
            failures++;
            $display("FAIL cnt_wrap got %04h expected 0000", retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_stall_hold();
        test_compare_flush();
        test_interrupt_flags();
        test_back_to_back();
        test_counter_wrap();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Pipeline stage directly downstream of the ALU in the pipelined PicoBlaze core.
- Registers each ALU result and drives the register-file write port.
- Owns the architectural ZERO/CARRY flags, including the interrupt save/restore pair (interrupt entry / RETURNI).
- Exposes a one-entry forwarding path back to the operand stage.

Parameters:
- OPERAND_WIDTH, 8, data width of result and register file.
- ADDR_WIDTH, 4, register-file address width (16 registers).
- COUNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU presents an instruction this cycle.
- alu_result  in  OPERAND_WIDTH  ALU result.
- alu_zero  in  1  zero flag computed by the ALU.
- alu_carry  in  1  carry flag computed by the ALU.
- alu_dest  in  ADDR_WIDTH  destination register.
- alu_wr_en  in  1  instruction writes the register file. Low for COMPARE and TEST.
- alu_upd_zero  in  1  instruction updates ZERO.
- alu_upd_carry  in  1  instruction updates CARRY.
- stall  in  1  hold stage contents; do not accept a new instruction.
- flush  in  1  discard the instruction being offered this cycle.
- int_save  in  1  interrupt accepted: preserve the flags.
- int_restore  in  1  RETURNI: restore the preserved flags.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  ADDR_WIDTH  write address.
- rf_wdata  out  OPERAND_WIDTH  write data.
- zero_flag  out  1  architectural ZERO.
- carry_flag  out  1  architectural CARRY.
- fwd_valid  out  1  forwarding entry holds a pending write.
- fwd_addr  out  ADDR_WIDTH  forwarding address.
- fwd_data  out  OPERAND_WIDTH  forwarding data.
- retired_count  out  COUNT_WIDTH  instructions accepted; wraps.
- ctl_err  out  1  sticky: int_save and int_restore were asserted together.

Behaviour:
- Reset (async, reset_n=0): every output and all internal state go to 0. This includes the stage valid, the saved flags, retired_count and ctl_err. Release is synchronous to the next rising edge.
- Accept condition: accept = alu_valid & !stall & !flush.
- Flush: flush overrides stall. At that edge the stage valid clears, and no flag update or count occurs for the offered instruction.
- On an accept edge:
  - Capture result, dest, wr_en.
  - Set stage valid.
  - Increment retired_count, wrapping 2^COUNT_WIDTH-1 -> 0.
- On a non-accept edge with !stall and !flush, the stage valid clears.
- Under stall the stage holds its contents. fwd_* remain asserted while the held entry is valid and wr_en=1.
- Register-file write:
  - rf_we is registered. It is high for exactly one cycle, the cycle after an accept edge, iff wr_en=1.
  - A stalled entry never re-writes.
  - rf_waddr/rf_wdata reflect the stage register.
  - Latency from ALU offer to register-file write: 1 cycle.
- Forwarding: fwd_valid = stage valid & wr_en. fwd_addr and fwd_data equal the stage contents.
- Flags, priority per edge (highest first):
  1. int_restore: zero_flag/carry_flag load the saved pair. A concurrent ALU update is ignored.
  2. Accept with upd bits: update the selected flag(s) from alu_zero/alu_carry. Flags not selected hold.
  3. Otherwise flags hold.
- int_save: the saved pair loads the flag values that result from this same edge (post-update).
- int_save & int_restore in the same cycle: restore is performed, save is ignored, ctl_err sets. ctl_err clears only on reset.
- Flags updated at edge N are visible in cycle N+1, concurrently with rf_we.
- Back-to-back accepts: every cycle is supported, giving one write per cycle with no bubbles.

Test Plan:
- Reset mid-operation: accept result=0x5A, dest=3, then drop reset_n asynchronously mid-cycle. All outputs must read 0 immediately, and no rf_we may follow reset release.
- Basic write: ADD offer result=0x00, zero=1, carry=1, dest=7, wr_en=1, both upd=1. Next cycle: rf_we=1, waddr=7, wdata=0x00, zero_flag=1, carry_flag=1, retired_count=1.
- Stall hold: accept result=0x3C, dest=2, then stall for 3 cycles while alu_valid=1. rf_we must be high for 1 cycle only. fwd_valid=1, fwd_addr=2, fwd_data=0x3C for all 3 cycles. retired_count advances by 1 only.
- COMPARE/flush: COMPARE with wr_en=0, upd_carry=1, carry=1 sets carry_flag=1 with no rf_we. Then an offer with flush=1 and stall=1 gives stage valid=0 and flags unchanged.
- Interrupt flags:
  - Set zero=1, carry=0, then pulse int_save.
  - Update to zero=0, carry=1.
  - Pulse int_restore together with an accepted update to zero=1, carry=1.
  - Flags must read zero=1, carry=0 (the restored pair).
  - Then pulse int_save and int_restore together: ctl_err=1, and it stays 1.
- Counter wrap: preload the count via 65535 accepts (or force) to 0xFFFF, then one more accept gives retired_count=0x0000.
